// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//   Turns debounced, active-high button levels into single-cycle event pulses.
//   Each channel runs its own IDLE/HELD/LONG FSM with a hold counter. The
//   channel emits Press on the first pressed sample and Release on the first
//   released sample. It emits Long once the hold reaches LONG_CYCLES, and
//   Repeat every REPEAT_CYCLES after that.
//
// Ports
//   Clk      system clock, rising edge
//   Reset    synchronous, active-high; returns every channel to IDLE
//   Input    [CHANNELS] debounced button levels, 1 = pressed
//   Press    [CHANNELS] 1-cycle pulse on press
//   Release  [CHANNELS] 1-cycle pulse on release
//   Long     [CHANNELS] 1-cycle pulse when the hold reaches LONG_CYCLES
//   Repeat   [CHANNELS] 1-cycle pulse every REPEAT_CYCLES after Long
//   Held     [CHANNELS] level, 1 while the channel is not IDLE
// -----------------------------------------------------------------------------
module button_event_decoder #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned LONG_CYCLES   = 50000000,
  parameter int unsigned REPEAT_CYCLES = 10000000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] Input,
  output logic [CHANNELS-1:0] Press,
  output logic [CHANNELS-1:0] Release,
  output logic [CHANNELS-1:0] Long,
  output logic [CHANNELS-1:0] Repeat,
  output logic [CHANNELS-1:0] Held
);

  localparam int unsigned MAX_CYCLES  = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W       = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_e;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             long_q, long_d;
    logic             repeat_q, repeat_d;
    logic             held_q, held_d;

    // Next-state and pulse decode; release wins over any threshold hit
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Input[g]) begin
            state_d = ST_HELD;
            cnt_d   = '0;
            press_d = 1'b1;
          end
        end
        ST_HELD: begin
          if (!Input[g]) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else if (cnt_q == LONG_LAST) begin
            state_d = ST_LONG;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_LONG: begin
          if (!Input[g]) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            release_d = 1'b1;
          end else if (cnt_q == REPEAT_LAST) begin
            cnt_d    = '0;
            repeat_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
      held_d = (state_d != ST_IDLE);
    end

    // State, counter and registered outputs
    always_ff @(posedge Clk) begin
      if (Reset) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
        held_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
        held_q    <= held_d;
      end
    end

    assign Press[g]   = press_q;
    assign Release[g] = release_q;
    assign Long[g]    = long_q;
    assign Repeat[g]  = repeat_q;
    assign Held[g]    = held_q;
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//   Directed bench for button_event_decoder with CHANNELS=4, LONG_CYCLES=8,
//   REPEAT_CYCLES=4. Edge e is the e-th rising edge of a scenario; outputs are
//   sampled 1 time unit after that edge and compared as the concatenation
//   {Press, Release, Long, Repeat, Held}.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  logic       Clk;
  logic       Reset;
  logic [3:0] Input;
  logic [3:0] Press;
  logic [3:0] Release;
  logic [3:0] Long;
  logic [3:0] Repeat;
  logic [3:0] Held;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] got;
  logic [19:0] exp_v;

  button_event_decoder #(
    .CHANNELS     (4),
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4)
  ) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Input  (Input),
    .Press  (Press),
    .Release(Release),
    .Long   (Long),
    .Repeat (Repeat),
    .Held   (Held)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_gap();
    Input = 4'b0000;
    Reset = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Input = 4'b1111;
    for (int e = 0; e < 2; e++) begin
      step();
      got   = {Press, Release, Long, Repeat, Held};
      exp_v = 20'h0;
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset edge %0d: got P/R/L/Rp/H=%b expected %b", e, got, exp_v);
      end
    end
    Input = 4'b0000;
    Reset = 1'b0;
    step();
    got = {Press, Release, Long, Repeat, Held};
    n_checks++;
    if (got !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_release idle: got %b expected %b", got, 20'h0);
    end
  endtask

  task automatic test_short_press();
    for (int e = 0; e <= 4; e++) begin
      Input = (e <= 2) ? 4'b0001 : 4'b0000;
      step();
      got   = {Press, Release, Long, Repeat, Held};
      exp_v = {(e == 0) ? 4'b0001 : 4'b0000,
               (e == 3) ? 4'b0001 : 4'b0000,
               4'b0000,
               4'b0000,
               (e <= 2) ? 4'b0001 : 4'b0000};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL short_press edge %0d: got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  task automatic test_long_hold();
    for (int e = 0; e <= 21; e++) begin
      Input = (e <= 19) ? 4'b0010 : 4'b0000;
      step();
      got   = {Press, Release, Long, Repeat, Held};
      exp_v = {(e == 0) ? 4'b0010 : 4'b0000,
               (e == 20) ? 4'b0010 : 4'b0000,
               (e == 8) ? 4'b0010 : 4'b0000,
               (e == 12 || e == 16) ? 4'b0010 : 4'b0000,
               (e <= 19) ? 4'b0010 : 4'b0000};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL long_hold edge %0d: got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  task automatic test_threshold();
    // Released exactly at the Long edge: only Release fires
    for (int e = 0; e <= 9; e++) begin
      Input = (e <= 7) ? 4'b0100 : 4'b0000;
      step();
      got   = {Press, Release, Long, Repeat, Held};
      exp_v = {(e == 0) ? 4'b0100 : 4'b0000,
               (e == 8) ? 4'b0100 : 4'b0000,
               4'b0000,
               4'b0000,
               (e <= 7) ? 4'b0100 : 4'b0000};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL threshold_short edge %0d: got %b expected %b", e, got, exp_v);
      end
    end
    // One more pressed sample reaches Long
    for (int e = 0; e <= 10; e++) begin
      Input = (e <= 8) ? 4'b0100 : 4'b0000;
      step();
      got   = {Press, Release, Long, Repeat, Held};
      exp_v = {(e == 0) ? 4'b0100 : 4'b0000,
               (e == 9) ? 4'b0100 : 4'b0000,
               (e == 8) ? 4'b0100 : 4'b0000,
               4'b0000,
               (e <= 8) ? 4'b0100 : 4'b0000};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL threshold_long edge %0d: got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int e = 0; e <= 21; e++) begin
      Input = (e <= 19) ? 4'b1000 : 4'b0000;
      Reset = (e == 10);
      step();
      got   = {Press, Release, Long, Repeat, Held};
      exp_v = {(e == 0 || e == 11) ? 4'b1000 : 4'b0000,
               (e == 20) ? 4'b1000 : 4'b0000,
               (e == 8 || e == 19) ? 4'b1000 : 4'b0000,
               4'b0000,
               (e <= 19 && e != 10) ? 4'b1000 : 4'b0000};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid edge %0d: got %b expected %b", e, got, exp_v);
      end
    end
    Reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [3:0] in_v  [6];
    logic [3:0] exp_p [6];
    logic [3:0] exp_r [6];
    logic [3:0] exp_h [6];
    in_v  = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    exp_p = '{4'b0011, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    exp_r = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0011, 4'b0000};
    exp_h = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0000, 4'b0000};
    for (int e = 0; e < 6; e++) begin
      Input = in_v[e];
      step();
      got   = {Press, Release, Long, Repeat, Held};
      exp_v = {exp_p[e], exp_r[e], 4'b0000, 4'b0000, exp_h[e]};
      n_checks++;
      if (got !== exp_v) begin
        n_fail++;
        $display("FAIL back_to_back edge %0d: got %b expected %b", e, got, exp_v);
      end
    end
  endtask

  initial begin
    Reset = 1'b1;
    Input = 4'b0000;
    test_reset();
    idle_gap();
    test_short_press();
    idle_gap();
    test_long_hold();
    idle_gap();
    test_threshold();
    idle_gap();
    test_reset_mid();
    idle_gap();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
